// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and DataPath.
// The controller side is the master; DataPath and memory sit on the slave side.
interface multicycle_controller_if #(
    parameter int OPC_W = 4
);
    logic [OPC_W-1:0] opcode;
    logic             toCU;
    logic             memReady;

    logic             pcEn;
    logic             selAddress;
    logic             mr;
    logic             mw;
    logic             DIEn;
    logic             LSEn;
    logic             RSEn;
    logic             dataRegEn;
    logic             selALUsrc;
    logic [2:0]       operation;
    logic             resultRegEn;
    logic             CEn;
    logic             ZEn;
    logic             NEn;
    logic             wordRegEn;
    logic [1:0]       selData;
    logic             enb;
    logic [1:0]       selAddressAC;
    logic             halted;
    logic             fault;
    logic [3:0]       state;

    modport master (
        input  opcode, toCU, memReady,
        output pcEn, selAddress, mr, mw, DIEn, LSEn, RSEn, dataRegEn, selALUsrc,
               operation, resultRegEn, CEn, ZEn, NEn, wordRegEn, selData, enb,
               selAddressAC, halted, fault, state
    );

    modport slave (
        output opcode, toCU, memReady,
        input  pcEn, selAddress, mr, mw, DIEn, LSEn, RSEn, dataRegEn, selALUsrc,
               operation, resultRegEn, CEn, ZEn, NEn, wordRegEn, selData, enb,
               selAddressAC, halted, fault, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit for DataPath: two-byte fetch, decode, operand read,
// execute and write-back/store/jump, with a per-access memory watchdog.
module multicycle_controller #(
    parameter int OPC_W   = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input logic                      clk,
    input logic                      reset,
    multicycle_controller_if.master  bus
);
    typedef enum logic [3:0] {
        S_F1    = 4'd0,
        S_F2    = 4'd1,
        S_DEC   = 4'd2,
        S_MRD   = 4'd3,
        S_EXE   = 4'd4,
        S_WB    = 4'd5,
        S_ST    = 4'd6,
        S_JMP   = 4'd7,
        S_HALT  = 4'd8,
        S_FAULT = 4'd9
    } state_t;

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STA = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_BRC = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_HLT = '1;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wd_cnt;
    logic             mem_wait;
    logic             timed_out;

    assign mem_wait  = (state_q == S_F1) || (state_q == S_F2) ||
                       (state_q == S_MRD) || (state_q == S_ST);
    assign timed_out = mem_wait && !bus.memReady && (wd_cnt == CNT_W'(TIMEOUT));
    assign bus.state = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_F1;
        else       state_q <= state_d;
    end

    // Watchdog counts consecutive not-ready cycles of the current access only.
    always_ff @(posedge clk) begin
        if (reset || (state_d != state_q)) wd_cnt <= '0;
        else if (mem_wait)                 wd_cnt <= bus.memReady ? '0 : wd_cnt + CNT_W'(1);
    end

    always_comb begin
        state_d          = state_q;
        bus.pcEn         = 1'b0;
        bus.selAddress   = 1'b0;
        bus.mr           = 1'b0;
        bus.mw           = 1'b0;
        bus.DIEn         = 1'b0;
        bus.LSEn         = 1'b0;
        bus.RSEn         = 1'b0;
        bus.dataRegEn    = 1'b0;
        bus.selALUsrc    = 1'b0;
        bus.operation    = 3'b000;
        bus.resultRegEn  = 1'b0;
        bus.CEn          = 1'b0;
        bus.ZEn          = 1'b0;
        bus.NEn          = 1'b0;
        bus.wordRegEn    = 1'b0;
        bus.selData      = 2'b00;
        bus.enb          = 1'b0;
        bus.selAddressAC = 2'b00;
        bus.halted       = 1'b0;
        bus.fault        = 1'b0;

        case (state_q)
            S_F1: begin
                bus.mr = 1'b1;
                if (bus.memReady) begin
                    bus.DIEn = 1'b1;
                    bus.LSEn = 1'b1;
                    bus.pcEn = 1'b1;
                    state_d  = S_F2;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end
            end
            S_F2: begin
                bus.mr = 1'b1;
                if (bus.memReady) begin
                    bus.DIEn = 1'b1;
                    bus.RSEn = 1'b1;
                    bus.pcEn = 1'b1;
                    state_d  = S_DEC;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end
            end
            S_DEC: begin
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_MRD;
                    OP_STA:  state_d = S_ST;
                    OP_JMP:  state_d = S_JMP;
                    OP_BRC:  state_d = bus.toCU ? S_JMP : S_F1;
                    OP_HLT:  state_d = S_HALT;
                    default: state_d = S_F1;
                endcase
            end
            S_MRD: begin
                bus.mr         = 1'b1;
                bus.selAddress = 1'b1;
                if (bus.memReady) begin
                    bus.DIEn      = 1'b1;
                    bus.dataRegEn = 1'b1;
                    state_d       = (bus.opcode == OP_LDA) ? S_WB : S_EXE;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end
            end
            S_EXE: begin
                bus.resultRegEn = 1'b1;
                case (bus.opcode)
                    OP_ADD: begin bus.operation = 3'b000; bus.CEn = 1'b1; bus.ZEn = 1'b1; bus.NEn = 1'b1; end
                    OP_SUB: begin bus.operation = 3'b001; bus.CEn = 1'b1; bus.ZEn = 1'b1; bus.NEn = 1'b1; end
                    OP_AND: begin bus.operation = 3'b010; bus.ZEn = 1'b1; bus.NEn = 1'b1; end
                    OP_OR:  begin bus.operation = 3'b011; bus.ZEn = 1'b1; bus.NEn = 1'b1; end
                    default: ;
                endcase
                state_d = S_WB;
            end
            S_WB: begin
                bus.wordRegEn = 1'b1;
                bus.selData   = (bus.opcode == OP_LDA) ? 2'b00 : 2'b01;
                state_d       = S_F1;
            end
            S_ST: begin
                bus.mw         = 1'b1;
                bus.enb        = 1'b1;
                bus.selAddress = 1'b1;
                if (bus.memReady)   state_d = S_F1;
                else if (timed_out) state_d = S_FAULT;
            end
            S_JMP: begin
                bus.pcEn         = 1'b1;
                bus.selAddressAC = 2'b01;
                state_d          = S_F1;
            end
            S_HALT:  bus.halted = 1'b1;
            S_FAULT: bus.fault  = 1'b1;
            // Unused encodings are treated as corruption and trapped.
            default: state_d = S_FAULT;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: a per-instruction cycle model expands
// each opcode into its expected per-cycle outputs and is compared cycle by cycle.
module tb_multicycle_controller;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic       pcEn, selAddress, mr, mw, DIEn, LSEn, RSEn, dataRegEn, selALUsrc;
        logic [2:0] operation;
        logic       resultRegEn, CEn, ZEn, NEn, wordRegEn;
        logic [1:0] selData;
        logic       enb;
        logic [1:0] selAddressAC;
        logic       halted, fault;
        logic [3:0] state;
    } obs_t;

    typedef struct {
        logic       rdy;
        logic [3:0] opc;
        logic       tc;
        obs_t       e;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    cyc_t q[$];
    obs_t act;

    multicycle_controller_if #(.OPC_W(4)) bus ();

    multicycle_controller #(.OPC_W(4), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign act = {bus.pcEn, bus.selAddress, bus.mr, bus.mw, bus.DIEn, bus.LSEn, bus.RSEn,
                  bus.dataRegEn, bus.selALUsrc, bus.operation, bus.resultRegEn, bus.CEn,
                  bus.ZEn, bus.NEn, bus.wordRegEn, bus.selData, bus.enb, bus.selAddressAC,
                  bus.halted, bus.fault, bus.state};

    function automatic logic [3:0] r4();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(logic rdy, logic [3:0] opc, logic tc, obs_t e);
        cyc_t c;
        c.rdy = rdy; c.opc = opc; c.tc = tc; c.e = e;
        q.push_back(c);
    endfunction

    // One memory access: w not-ready cycles then a ready cycle; more than TIMEOUT waits traps.
    function automatic bit mem_step(obs_t wait_e, obs_t rdy_e, int w, logic [3:0] opc, bit any_opc);
        obs_t f;
        int   n = (w > TIMEOUT) ? TIMEOUT + 1 : w;
        for (int i = 0; i < n; i++) push(1'b0, any_opc ? r4() : opc, r1(), wait_e);
        if (w <= TIMEOUT) begin
            push(1'b1, any_opc ? r4() : opc, r1(), rdy_e);
            return 1'b0;
        end
        f = '0; f.state = 4'd9; f.fault = 1'b1;
        for (int i = 0; i < 5; i++) push(r1(), r4(), r1(), f);
        return 1'b1;
    endfunction

    // Expected cycles of one instruction, from fetch through its final step.
    function automatic void gen_instr(logic [3:0] opc, logic tc, int w1, int w2, int w3);
        obs_t we, re;
        bit   alu = (opc >= 4'd2) && (opc <= 4'd5);
        we = '0; we.state = 4'd0; we.mr = 1'b1;
        re = we; re.DIEn = 1'b1; re.LSEn = 1'b1; re.pcEn = 1'b1;
        if (mem_step(we, re, w1, opc, 1'b1)) return;
        we.state = 4'd1;
        re = we; re.DIEn = 1'b1; re.RSEn = 1'b1; re.pcEn = 1'b1;
        if (mem_step(we, re, w2, opc, 1'b1)) return;
        we = '0; we.state = 4'd2;
        push(r1(), opc, tc, we);
        if (opc == 4'd0 || alu) begin
            we = '0; we.state = 4'd3; we.mr = 1'b1; we.selAddress = 1'b1;
            re = we; re.DIEn = 1'b1; re.dataRegEn = 1'b1;
            if (mem_step(we, re, w3, opc, 1'b0)) return;
            if (alu) begin
                we = '0; we.state = 4'd4; we.resultRegEn = 1'b1;
                we.operation = 3'(opc - 4'd2);
                we.ZEn = 1'b1; we.NEn = 1'b1; we.CEn = (opc <= 4'd3);
                push(r1(), opc, r1(), we);
            end
            we = '0; we.state = 4'd5; we.wordRegEn = 1'b1; we.selData = alu ? 2'b01 : 2'b00;
            push(r1(), opc, r1(), we);
        end else if (opc == 4'd1) begin
            we = '0; we.state = 4'd6; we.mw = 1'b1; we.enb = 1'b1; we.selAddress = 1'b1;
            void'(mem_step(we, we, w3, opc, 1'b0));
        end else if (opc == 4'd6 || (opc == 4'd7 && tc)) begin
            we = '0; we.state = 4'd7; we.pcEn = 1'b1; we.selAddressAC = 2'b01;
            push(r1(), opc, r1(), we);
        end else if (opc == 4'd15) begin
            we = '0; we.state = 4'd8; we.halted = 1'b1;
            for (int i = 0; i < 8; i++) push(i[0], r4(), r1(), we);
        end
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.memReady = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        do_reset(2);
        bus.memReady = 1'b0; bus.opcode = 4'd2; bus.toCU = 1'b0;
        #1;
        e = '0; e.mr = 1'b1;
        total++;
        if (act !== e) begin bad++; $display("FAIL reset_state got=%h want=%h", act, e); end
        bus.memReady = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (bus.state !== 4'd4) begin bad++; $display("FAIL reach_exe state=%0d want=4", bus.state); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.memReady = 1'b0;
        #1;
        total++;
        if (act !== e) begin bad++; $display("FAIL reset_mid_exe got=%h want=%h", act, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_lda();
        int n = 0;
        do_reset(1);
        gen_instr(4'd0, 1'b0, 0, 0, 0);
        gen_instr(4'd0, 1'b1, 2, 1, 3);
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            bus.memReady = c.rdy; bus.opcode = c.opc; bus.toCU = c.tc;
            #1;
            total++;
            if (act !== c.e) begin bad++; $display("FAIL lda cyc=%0d got=%h want=%h", n, act, c.e); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        int n = 0;
        do_reset(1);
        gen_instr(4'd3, 1'b0, 0, 0, 3);
        for (int op = 2; op <= 5; op++)
            gen_instr(4'(op), r1(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            bus.memReady = c.rdy; bus.opcode = c.opc; bus.toCU = c.tc;
            #1;
            total++;
            if (act !== c.e) begin bad++; $display("FAIL alu cyc=%0d got=%h want=%h", n, act, c.e); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        int n = 0;
        do_reset(1);
        gen_instr(4'd7, 1'b0, 0, 0, 0);
        gen_instr(4'd7, 1'b1, 0, 0, 0);
        gen_instr(4'd6, 1'b0, 1, 0, 0);
        gen_instr(4'd1, 1'b1, 0, 2, 4);
        gen_instr(4'd9, 1'b1, 0, 0, 0);
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            bus.memReady = c.rdy; bus.opcode = c.opc; bus.toCU = c.tc;
            #1;
            total++;
            if (act !== c.e) begin bad++; $display("FAIL branch cyc=%0d got=%h want=%h", n, act, c.e); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset(1);
        for (int i = 0; i < 25; i++)
            gen_instr(4'($urandom_range(0, 14)), r1(), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            bus.memReady = c.rdy; bus.opcode = c.opc; bus.toCU = c.tc;
            #1;
            total++;
            if (act !== c.e) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", n, act, c.e); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        for (int k = 0; k < 4; k++) begin
            do_reset(1);
            case (k)
                0: gen_instr(4'd0, 1'b0, 20, 0, 0);
                1: gen_instr(4'd9, 1'b0, 15, 15, 0);
                2: gen_instr(4'd4, 1'b0, 0, 0, 16);
                default: gen_instr(4'd1, 1'b0, 0, 0, 15);
            endcase
            while (q.size() > 0) begin
                cyc_t c;
                c = q.pop_front();
                bus.memReady = c.rdy; bus.opcode = c.opc; bus.toCU = c.tc;
                #1;
                total++;
                if (act !== c.e) begin bad++; $display("FAIL timeout%0d cyc=%0d got=%h want=%h", k, n, act, c.e); end
                n++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_halt();
        obs_t e;
        int   n = 0;
        do_reset(1);
        gen_instr(4'd15, 1'b0, 1, 0, 0);
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            bus.memReady = c.rdy; bus.opcode = c.opc; bus.toCU = c.tc;
            #1;
            total++;
            if (act !== c.e) begin bad++; $display("FAIL halt cyc=%0d got=%h want=%h", n, act, c.e); end
            n++;
            @(posedge clk); #1;
        end
        do_reset(1);
        bus.memReady = 1'b0;
        #1;
        e = '0; e.mr = 1'b1;
        total++;
        if (act !== e) begin bad++; $display("FAIL halt_reset got=%h want=%h", act, e); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.memReady = 1'b0;
        bus.opcode   = 4'd0;
        bus.toCU     = 1'b0;
        test_reset();
        test_lda();
        test_alu();
        test_branch();
        test_back_to_back();
        test_timeout();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
